// File: rtl/id_ex_operand_latch_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_operand_latch_pkg
//
// Shared definitions for the ID/EX operand latch and its forwarding mux.
//   FWD_RF / FWD_EX / FWD_MEM / FWD_WB : forward-select codes as produced by
//                                        the forwarding unit
//   CTRL_W                             : width of the EX/MEM/WB control bundle
// ---------------------------------------------------------------------------
package id_ex_operand_latch_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int CTRL_W = 12;

endpackage

// File: rtl/id_ex_operand_latch_fwd_operand_mux.sv
// ---------------------------------------------------------------------------
// fwd_operand_mux
//
// Purely combinational 4:1 operand select. It is driven by a forwarding code
// and chooses between the register-file value and the three in-flight results.
// Ports:
//   sel        in  FBITS   : forward code (FWD_RF/FWD_EX/FWD_MEM/FWD_WB)
//   rf_data    in  NB_DATA : register-file read data
//   ex_result  in  NB_DATA : EX-stage result
//   mem_result in  NB_DATA : EX/MEM result
//   wb_result  in  NB_DATA : MEM/WB result
//   data_out   out NB_DATA : selected operand
// ---------------------------------------------------------------------------
module fwd_operand_mux
  import id_ex_operand_latch_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int FBITS   = 2
) (
  input  logic [FBITS-1:0]   sel,
  input  logic [NB_DATA-1:0] rf_data,
  input  logic [NB_DATA-1:0] ex_result,
  input  logic [NB_DATA-1:0] mem_result,
  input  logic [NB_DATA-1:0] wb_result,
  output logic [NB_DATA-1:0] data_out
);

  // Any code outside the four defined ones falls back to the register file.
  always_comb begin
    data_out = rf_data;
    case (sel)
      FBITS'(FWD_RF):  data_out = rf_data;
      FBITS'(FWD_EX):  data_out = ex_result;
      FBITS'(FWD_MEM): data_out = mem_result;
      FBITS'(FWD_WB):  data_out = wb_result;
      default:         data_out = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_latch.sv
// ---------------------------------------------------------------------------
// id_ex_operand_latch
//
// ID/EX pipeline register of the MIPS core. It sits right after the
// forwarding unit. Each source operand is picked from the register file or
// one of the three forwarding sources. The operands are then latched into EX
// together with the immediate, the register numbers and the control bundle.
// A stall or a flush loads a bubble instead. The enable input, driven by the
// debug unit, freezes the whole register.
//
// Ports:
//   clk, rst_n                        : clock, async active-low reset
//   enable                            : 0 holds every output
//   stall                             : load-use bubble (counted)
//   flush                             : branch/jump bubble (not counted)
//   IF_ID_rs/rt/rd                    : ID-stage register numbers
//   forward_A/B                       : operand forward codes
//   rf_data_a/b                       : register-file read data
//   ex_result, mem_result, wb_result  : forwarding sources
//   ID_imm, ID_ctrl, ID_regwrite      : decoded immediate/control/write enable
//   EX_op_a/b, EX_imm                 : latched operands and immediate
//   EX_rs, EX_rt, ID_EX_rd            : latched register numbers
//   EX_ctrl, ID_EX_regwrite           : latched control
//   EX_valid                          : 1 = real instruction, 0 = bubble
//
// Optional feature (macro ID_EX_STALL_CNT_EN):
//   cnt_clr     in  : synchronous counter clear, gated by enable
//   stall_count out : saturating count of stall bubbles
// ---------------------------------------------------------------------------
module id_ex_operand_latch
  import id_ex_operand_latch_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int RBITS   = 5,
  parameter int FBITS   = 2,
  parameter int NB_CTRL = CTRL_W,
  parameter int NB_CNT  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               stall,
  input  logic               flush,
  input  logic [RBITS-1:0]   IF_ID_rs,
  input  logic [RBITS-1:0]   IF_ID_rt,
  input  logic [RBITS-1:0]   IF_ID_rd,
  input  logic [FBITS-1:0]   forward_A,
  input  logic [FBITS-1:0]   forward_B,
  input  logic [NB_DATA-1:0] rf_data_a,
  input  logic [NB_DATA-1:0] rf_data_b,
  input  logic [NB_DATA-1:0] ex_result,
  input  logic [NB_DATA-1:0] mem_result,
  input  logic [NB_DATA-1:0] wb_result,
  input  logic [NB_DATA-1:0] ID_imm,
  input  logic [NB_CTRL-1:0] ID_ctrl,
  input  logic               ID_regwrite,
  output logic [NB_DATA-1:0] EX_op_a,
  output logic [NB_DATA-1:0] EX_op_b,
  output logic [NB_DATA-1:0] EX_imm,
  output logic [RBITS-1:0]   EX_rs,
  output logic [RBITS-1:0]   EX_rt,
  output logic [RBITS-1:0]   ID_EX_rd,
  output logic [NB_CTRL-1:0] EX_ctrl,
  output logic               ID_EX_regwrite,
  output logic               EX_valid
`ifdef ID_EX_STALL_CNT_EN
  ,
  input  logic               cnt_clr,
  output logic [NB_CNT-1:0]  stall_count
`endif
);

  logic [NB_DATA-1:0] sel_a;
  logic [NB_DATA-1:0] sel_b;

  logic [NB_DATA-1:0] op_a_q,     op_a_d;
  logic [NB_DATA-1:0] op_b_q,     op_b_d;
  logic [NB_DATA-1:0] imm_q,      imm_d;
  logic [RBITS-1:0]   rs_q,       rs_d;
  logic [RBITS-1:0]   rt_q,       rt_d;
  logic [RBITS-1:0]   rd_q,       rd_d;
  logic [NB_CTRL-1:0] ctrl_q,     ctrl_d;
  logic               regwrite_q, regwrite_d;
  logic               valid_q,    valid_d;

  fwd_operand_mux #(
    .NB_DATA (NB_DATA),
    .FBITS   (FBITS)
  ) u_mux_a (
    .sel        (forward_A),
    .rf_data    (rf_data_a),
    .ex_result  (ex_result),
    .mem_result (mem_result),
    .wb_result  (wb_result),
    .data_out   (sel_a)
  );

  fwd_operand_mux #(
    .NB_DATA (NB_DATA),
    .FBITS   (FBITS)
  ) u_mux_b (
    .sel        (forward_B),
    .rf_data    (rf_data_b),
    .ex_result  (ex_result),
    .mem_result (mem_result),
    .wb_result  (wb_result),
    .data_out   (sel_b)
  );

  // Next-state: hold when disabled. Otherwise flush and stall both load an
  // all-zero bubble; only the counter tells them apart.
  always_comb begin
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    regwrite_d = regwrite_q;
    valid_d    = valid_q;
    if (enable) begin
      if (flush || stall) begin
        op_a_d     = '0;
        op_b_d     = '0;
        imm_d      = '0;
        rs_d       = '0;
        rt_d       = '0;
        rd_d       = '0;
        ctrl_d     = '0;
        regwrite_d = 1'b0;
        valid_d    = 1'b0;
      end else begin
        op_a_d     = sel_a;
        op_b_d     = sel_b;
        imm_d      = ID_imm;
        rs_d       = IF_ID_rs;
        rt_d       = IF_ID_rt;
        rd_d       = IF_ID_rd;
        ctrl_d     = ID_ctrl;
        regwrite_d = ID_regwrite;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      regwrite_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      regwrite_q <= regwrite_d;
      valid_q    <= valid_d;
    end
  end

  assign EX_op_a        = op_a_q;
  assign EX_op_b        = op_b_q;
  assign EX_imm         = imm_q;
  assign EX_rs          = rs_q;
  assign EX_rt          = rt_q;
  assign ID_EX_rd       = rd_q;
  assign EX_ctrl        = ctrl_q;
  assign ID_EX_regwrite = regwrite_q;
  assign EX_valid       = valid_q;

`ifdef ID_EX_STALL_CNT_EN
  logic [NB_CNT-1:0] stall_count_q, stall_count_d;

  // Only stall bubbles are counted. A flush in the same cycle takes
  // precedence, so that cycle is not counted. Clear beats increment, and the
  // count sticks at all-ones.
  always_comb begin
    stall_count_d = stall_count_q;
    if (enable) begin
      if (cnt_clr) begin
        stall_count_d = '0;
      end else if (stall && !flush && (stall_count_q != {NB_CNT{1'b1}})) begin
        stall_count_d = stall_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  // Keeps NB_CNT referenced in builds without the counter.
  logic [NB_CNT-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_id_ex_operand_latch.sv
// ---------------------------------------------------------------------------
// tb_id_ex_operand_latch
//
// Directed bench for the ID/EX operand latch. It covers reset, forward
// selection for both operands, stall/flush bubbles, the enable freeze and an
// asynchronous mid-run reset. With ID_EX_STALL_CNT_EN defined it also checks
// the stall counter, including saturation on a second copy built with
// NB_CNT=2.
// ---------------------------------------------------------------------------
module tb_id_ex_operand_latch;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        stall;
  logic        flush;
  logic [4:0]  IF_ID_rs;
  logic [4:0]  IF_ID_rt;
  logic [4:0]  IF_ID_rd;
  logic [1:0]  forward_A;
  logic [1:0]  forward_B;
  logic [31:0] rf_data_a;
  logic [31:0] rf_data_b;
  logic [31:0] ex_result;
  logic [31:0] mem_result;
  logic [31:0] wb_result;
  logic [31:0] ID_imm;
  logic [11:0] ID_ctrl;
  logic        ID_regwrite;
  logic [31:0] EX_op_a;
  logic [31:0] EX_op_b;
  logic [31:0] EX_imm;
  logic [4:0]  EX_rs;
  logic [4:0]  EX_rt;
  logic [4:0]  ID_EX_rd;
  logic [11:0] EX_ctrl;
  logic        ID_EX_regwrite;
  logic        EX_valid;
`ifdef ID_EX_STALL_CNT_EN
  logic        cnt_clr;
  logic [15:0] stall_count;
  logic [31:0] sat_op_a;
  logic [31:0] sat_op_b;
  logic [31:0] sat_imm;
  logic [4:0]  sat_rs;
  logic [4:0]  sat_rt;
  logic [4:0]  sat_rd;
  logic [11:0] sat_ctrl;
  logic        sat_regwrite;
  logic        sat_valid;
  logic [1:0]  sat_stall_count;
`endif

  int check_count = 0;
  int fail_count  = 0;

  id_ex_operand_latch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .stall          (stall),
    .flush          (flush),
    .IF_ID_rs       (IF_ID_rs),
    .IF_ID_rt       (IF_ID_rt),
    .IF_ID_rd       (IF_ID_rd),
    .forward_A      (forward_A),
    .forward_B      (forward_B),
    .rf_data_a      (rf_data_a),
    .rf_data_b      (rf_data_b),
    .ex_result      (ex_result),
    .mem_result     (mem_result),
    .wb_result      (wb_result),
    .ID_imm         (ID_imm),
    .ID_ctrl        (ID_ctrl),
    .ID_regwrite    (ID_regwrite),
    .EX_op_a        (EX_op_a),
    .EX_op_b        (EX_op_b),
    .EX_imm         (EX_imm),
    .EX_rs          (EX_rs),
    .EX_rt          (EX_rt),
    .ID_EX_rd       (ID_EX_rd),
    .EX_ctrl        (EX_ctrl),
    .ID_EX_regwrite (ID_EX_regwrite),
    .EX_valid       (EX_valid)
`ifdef ID_EX_STALL_CNT_EN
    ,
    .cnt_clr        (cnt_clr),
    .stall_count    (stall_count)
`endif
  );

`ifdef ID_EX_STALL_CNT_EN
  id_ex_operand_latch #(.NB_CNT(2)) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .stall          (stall),
    .flush          (flush),
    .IF_ID_rs       (IF_ID_rs),
    .IF_ID_rt       (IF_ID_rt),
    .IF_ID_rd       (IF_ID_rd),
    .forward_A      (forward_A),
    .forward_B      (forward_B),
    .rf_data_a      (rf_data_a),
    .rf_data_b      (rf_data_b),
    .ex_result      (ex_result),
    .mem_result     (mem_result),
    .wb_result      (wb_result),
    .ID_imm         (ID_imm),
    .ID_ctrl        (ID_ctrl),
    .ID_regwrite    (ID_regwrite),
    .EX_op_a        (sat_op_a),
    .EX_op_b        (sat_op_b),
    .EX_imm         (sat_imm),
    .EX_rs          (sat_rs),
    .EX_rt          (sat_rt),
    .ID_EX_rd       (sat_rd),
    .EX_ctrl        (sat_ctrl),
    .ID_EX_regwrite (sat_regwrite),
    .EX_valid       (sat_valid),
    .cnt_clr        (cnt_clr),
    .stall_count    (sat_stall_count)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the control inputs, then advances past one rising edge so the
  // caller samples 1 time unit after it.
  task automatic applyStimulus(input logic en, input logic st, input logic fl,
                               input logic [1:0] fa, input logic [1:0] fb);
    enable    = en;
    stall     = st;
    flush     = fl;
    forward_A = fa;
    forward_B = fb;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    IF_ID_rs    = 5'd1;
    IF_ID_rt    = 5'd2;
    IF_ID_rd    = 5'd3;
    forward_A   = 2'd0;
    forward_B   = 2'd0;
    rf_data_a   = 32'h11;
    rf_data_b   = 32'h55;
    ex_result   = 32'h22;
    mem_result  = 32'h33;
    wb_result   = 32'h44;
    ID_imm      = 32'h1234;
    ID_ctrl     = 12'hABC;
    ID_regwrite = 1'b1;
`ifdef ID_EX_STALL_CNT_EN
    cnt_clr     = 1'b0;
`endif

    // Reset state
    #12;
    checkOutput("rst_valid", 64'(EX_valid), 64'h0);
    checkOutput("rst_op_a", 64'(EX_op_a), 64'h0);
    checkOutput("rst_ctrl", 64'(EX_ctrl), 64'h0);
    checkOutput("rst_regwrite", 64'(ID_EX_regwrite), 64'h0);
`ifdef ID_EX_STALL_CNT_EN
    checkOutput("rst_count", 64'(stall_count), 64'h0);
`endif
    rst_n = 1'b1;

    // Forward sweep A, with a full field check on the first load
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    checkOutput("fwdA_rf", 64'(EX_op_a), 64'h11);
    checkOutput("load_op_b", 64'(EX_op_b), 64'h55);
    checkOutput("load_imm", 64'(EX_imm), 64'h1234);
    checkOutput("load_rs", 64'(EX_rs), 64'd1);
    checkOutput("load_rt", 64'(EX_rt), 64'd2);
    checkOutput("load_rd", 64'(ID_EX_rd), 64'd3);
    checkOutput("load_ctrl", 64'(EX_ctrl), 64'hABC);
    checkOutput("load_regwrite", 64'(ID_EX_regwrite), 64'h1);
    checkOutput("load_valid", 64'(EX_valid), 64'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 2'd0);
    checkOutput("fwdA_ex", 64'(EX_op_a), 64'h22);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 2'd0);
    checkOutput("fwdA_mem", 64'(EX_op_a), 64'h33);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd3, 2'd0);
    checkOutput("fwdA_wb", 64'(EX_op_a), 64'h44);

    // Forward sweep B
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    checkOutput("fwdB_rf", 64'(EX_op_b), 64'h55);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 2'd1);
    checkOutput("fwdB_ex", 64'(EX_op_b), 64'h22);
    checkOutput("fwdB_ex_a", 64'(EX_op_a), 64'h11);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 2'd2);
    checkOutput("fwdB_mem", 64'(EX_op_b), 64'h33);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 2'd3);
    checkOutput("fwdB_wb", 64'(EX_op_b), 64'h44);

    // Two stall bubbles with a writing instruction to rd=5 waiting in ID
    IF_ID_rd    = 5'd5;
    ID_regwrite = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 2'd1);
      checkOutput("stall_regwrite", 64'(ID_EX_regwrite), 64'h0);
      checkOutput("stall_rd", 64'(ID_EX_rd), 64'h0);
      checkOutput("stall_valid", 64'(EX_valid), 64'h0);
      checkOutput("stall_op_a", 64'(EX_op_a), 64'h0);
    end
`ifdef ID_EX_STALL_CNT_EN
    checkOutput("stall_count2", 64'(stall_count), 64'd2);
`endif

    // Stall released: the instruction enters EX
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 2'd2);
    checkOutput("resume_rd", 64'(ID_EX_rd), 64'd5);
    checkOutput("resume_op_a", 64'(EX_op_a), 64'h22);
    checkOutput("resume_op_b", 64'(EX_op_b), 64'h33);
    checkOutput("resume_valid", 64'(EX_valid), 64'h1);

    // Flush together with stall: bubble, counter unchanged
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 2'd0);
    checkOutput("fs_valid", 64'(EX_valid), 64'h0);
    checkOutput("fs_ctrl", 64'(EX_ctrl), 64'h0);
    checkOutput("fs_imm", 64'(EX_imm), 64'h0);
`ifdef ID_EX_STALL_CNT_EN
    checkOutput("fs_count", 64'(stall_count), 64'd2);
`endif

    // Flush alone
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd3, 2'd0);
    checkOutput("pre_flush_op_a", 64'(EX_op_a), 64'h44);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 2'd0);
    checkOutput("flush_op_a", 64'(EX_op_a), 64'h0);
    checkOutput("flush_rs", 64'(EX_rs), 64'h0);
    checkOutput("flush_valid", 64'(EX_valid), 64'h0);
`ifdef ID_EX_STALL_CNT_EN
    checkOutput("flush_count", 64'(stall_count), 64'd2);
`endif

    // Enable low: three frozen edges while inputs toggle and flush is high
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    checkOutput("pre_hold_op_a", 64'(EX_op_a), 64'h11);
    for (int i = 0; i < 3; i++) begin
      rf_data_a   = 32'h99 + 32'(i);
      IF_ID_rd    = 5'd7 + 5'(i);
      ID_ctrl     = 12'h123 + 12'(i);
      ID_regwrite = i[0];
      applyStimulus(1'b0, i[1], 1'b1, 2'(i), 2'(i + 1));
      checkOutput("hold_op_a", 64'(EX_op_a), 64'h11);
      checkOutput("hold_rd", 64'(ID_EX_rd), 64'd5);
      checkOutput("hold_ctrl", 64'(EX_ctrl), 64'hABC);
      checkOutput("hold_valid", 64'(EX_valid), 64'h1);
      checkOutput("hold_regwrite", 64'(ID_EX_regwrite), 64'h1);
    end
`ifdef ID_EX_STALL_CNT_EN
    checkOutput("hold_count", 64'(stall_count), 64'd2);
`endif

    // Asynchronous reset during a stall, checked before any clock edge
    rf_data_a   = 32'h11;
    ID_regwrite = 1'b1;
    enable      = 1'b1;
    stall       = 1'b1;
    flush       = 1'b0;
    rst_n       = 1'b0;
    #2;
    checkOutput("arst_valid", 64'(EX_valid), 64'h0);
    checkOutput("arst_op_a", 64'(EX_op_a), 64'h0);
    checkOutput("arst_rd", 64'(ID_EX_rd), 64'h0);
    checkOutput("arst_ctrl", 64'(EX_ctrl), 64'h0);
    checkOutput("arst_regwrite", 64'(ID_EX_regwrite), 64'h0);
`ifdef ID_EX_STALL_CNT_EN
    checkOutput("arst_count", 64'(stall_count), 64'h0);
`endif
    @(posedge clk);
    #1;
    stall = 1'b0;
    rst_n = 1'b1;
`ifdef ID_EX_STALL_CNT_EN
    checkOutput("arst_count_after_edge", 64'(stall_count), 64'h0);
`endif

    // Back in service after reset
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 2'd3);
    checkOutput("post_rst_op_a", 64'(EX_op_a), 64'h33);
    checkOutput("post_rst_op_b", 64'(EX_op_b), 64'h44);
    checkOutput("post_rst_valid", 64'(EX_valid), 64'h1);

`ifdef ID_EX_STALL_CNT_EN
    // Saturation on the 2-bit copy, then clear beating a stall
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    end
    checkOutput("sat_count", 64'(sat_stall_count), 64'd3);
    checkOutput("wide_count", 64'(stall_count), 64'd5);
    cnt_clr = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
    cnt_clr = 1'b0;
    checkOutput("clr_sat_count", 64'(sat_stall_count), 64'd0);
    checkOutput("clr_wide_count", 64'(stall_count), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

  // Guards against the run never reaching its summary line.
  initial begin
    #50000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
